// File: rtl/mult_hilo_unit_if.sv
// Interface between the execute stage, the 16x16 sequential multiplier and the HI/LO controller.
// The slave modport is the controller's view; master is the surrounding pipeline and multiplier.
interface mult_hilo_unit_if #(
   parameter int unsigned DATA_W = 16
);
   logic                Req_Valid;
   logic                Req_Ready;
   logic [DATA_W-1:0]   Op_A;
   logic [DATA_W-1:0]   Op_B;
   logic                Mul_St;
   logic [DATA_W-1:0]   Mul_Multiplicando;
   logic [DATA_W-1:0]   Mul_Multiplicador;
   logic                Mul_Done;
   logic                Mul_Idle;
   logic [2*DATA_W-1:0] Mul_Produto;
   logic                Rd_Req;
   logic                Rd_Sel;
   logic [DATA_W-1:0]   Rd_Data;
   logic                Stall;
   logic                Busy;
   logic                Erro;

   modport slave (
      input  Req_Valid, Op_A, Op_B, Mul_Done, Mul_Idle, Mul_Produto, Rd_Req, Rd_Sel,
      output Req_Ready, Mul_St, Mul_Multiplicando, Mul_Multiplicador, Rd_Data, Stall, Busy, Erro
   );

   modport master (
      output Req_Valid, Op_A, Op_B, Mul_Done, Mul_Idle, Mul_Produto, Rd_Req, Rd_Sel,
      input  Req_Ready, Mul_St, Mul_Multiplicando, Mul_Multiplicador, Rd_Data, Stall, Busy, Erro
   );
endinterface

// File: rtl/mult_hilo_unit.sv
// MULT controller: latches operands, launches the sequential multiplier, waits for a Done rise
// and commits the product into HI/LO; serves MFHI/MFLO reads and stalls while busy.
module mult_hilo_unit #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              Clk,
   input  logic              Rst_n,
   mult_hilo_unit_if.slave   bus
);
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  hi_q, hi_d;
   logic [DATA_W-1:0]  lo_q, lo_d;
   logic [DATA_W-1:0]  opa_q, opa_d;
   logic [DATA_W-1:0]  opb_q, opb_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               erro_q, erro_d;
   logic               done_q;
   logic               mul_st;
   logic               done_rise;

   // A Done left high by the previous operation must not complete the current one.
   assign done_rise = bus.Mul_Done & ~done_q;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         cnt_q   <= '0;
         erro_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         cnt_q   <= cnt_d;
         erro_q  <= erro_d;
         done_q  <= bus.Mul_Done;
      end
   end

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      cnt_d   = cnt_q;
      erro_d  = erro_q;
      mul_st  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.Req_Valid) begin
               opa_d   = bus.Op_A;
               opb_d   = bus.Op_B;
               erro_d  = 1'b0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bus.Mul_Idle) begin
               mul_st  = 1'b1;
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (done_rise) begin
               hi_d    = bus.Mul_Produto[2*DATA_W-1:DATA_W];
               lo_d    = bus.Mul_Produto[DATA_W-1:0];
               state_d = S_IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               erro_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.Req_Ready         = (state_q == S_IDLE);
   assign bus.Busy              = (state_q != S_IDLE);
   assign bus.Mul_St            = mul_st;
   assign bus.Mul_Multiplicando = opa_q;
   assign bus.Mul_Multiplicador = opb_q;
   assign bus.Rd_Data           = bus.Rd_Sel ? hi_q : lo_q;
   assign bus.Stall             = bus.Rd_Req & (state_q != S_IDLE);
   assign bus.Erro              = erro_q;
endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit with a behavioural stand-in for the sequential multiplier.
module tb_mult_hilo_unit;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mult_hilo_unit_if #(.DATA_W(16)) bus ();

   mult_hilo_unit #(.DATA_W(16), .TIMEOUT(64)) dut (
      .Clk   (clk),
      .Rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Multiplier stand-in: Done rises lat edges after St and is held until the edge after the next St;
   // Idle returns idle_gap edges after Done. It is deliberately not reset with the DUT.
   int unsigned lat      = 5;
   int unsigned idle_gap = 0;
   logic        done_en  = 1'b1;
   int unsigned bcnt     = 0;
   int unsigned icnt     = 0;
   logic        m_done   = 1'b0;
   logic        m_idle   = 1'b1;
   logic [31:0] m_prod   = '0;
   logic [31:0] pend     = '0;

   assign bus.Mul_Done    = m_done;
   assign bus.Mul_Idle    = m_idle;
   assign bus.Mul_Produto = m_prod;

   always @(posedge clk) begin
      if (bus.Mul_St) begin
         bcnt   <= lat;
         m_idle <= 1'b0;
         pend   <= {16'h0, bus.Mul_Multiplicando} * {16'h0, bus.Mul_Multiplicador};
      end else if (bcnt != 0) begin
         bcnt <= bcnt - 1;
         if (bcnt == lat) m_done <= 1'b0;
         if (bcnt == 1) begin
            m_done <= done_en;
            m_prod <= pend;
            if (idle_gap == 0) m_idle <= 1'b1;
            else icnt <= idle_gap;
         end
      end else if (icnt != 0) begin
         icnt <= icnt - 1;
         if (icnt == 1) m_idle <= 1'b1;
      end
   end

   int unsigned st_cnt = 0;
   always @(negedge clk) if (bus.Mul_St) st_cnt++;

   task automatic issue(input logic [15:0] a, input logic [15:0] b);
      bus.Req_Valid = 1'b1;
      bus.Op_A      = a;
      bus.Op_B      = b;
      @(negedge clk);
      bus.Req_Valid = 1'b0;
   endtask

   task automatic wait_ready(input int unsigned budget, output int unsigned busy_cyc,
                             output int unsigned stall_cyc);
      busy_cyc  = 0;
      stall_cyc = 0;
      while (bus.Busy && busy_cyc < budget) begin
         busy_cyc++;
         if (bus.Stall) stall_cyc++;
         @(negedge clk);
      end
      chk("ready_in_budget", {31'h0, bus.Req_Ready}, 32'h1);
   endtask

   task automatic rd(input logic sel, output logic [15:0] val);
      bus.Rd_Sel = sel;
      #1;
      val = bus.Rd_Data;
   endtask

   int unsigned bc, sc, st0;
   logic [15:0] v;

   initial begin
      bus.Req_Valid = 1'b0;
      bus.Op_A      = '0;
      bus.Op_B      = '0;
      bus.Rd_Req    = 1'b0;
      bus.Rd_Sel    = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("rst_ready", {31'h0, bus.Req_Ready}, 32'h1);
      chk("rst_busy",  {31'h0, bus.Busy}, 32'h0);
      chk("rst_st",    {31'h0, bus.Mul_St}, 32'h0);
      chk("rst_erro",  {31'h0, bus.Erro}, 32'h0);
      chk("rst_opa",   {16'h0, bus.Mul_Multiplicando}, 32'h0);
      rd(1'b1, v); chk("rst_hi", {16'h0, v}, 32'h0);
      rd(1'b0, v); chk("rst_lo", {16'h0, v}, 32'h0);
      @(negedge clk);

      // 3 x 5
      st0 = st_cnt;
      issue(16'd3, 16'd5);
      wait_ready(200, bc, sc);
      chk("s1_st_pulses", st_cnt - st0, 32'd1);
      rd(1'b0, v); chk("s1_lo", {16'h0, v}, 32'd15);
      rd(1'b1, v); chk("s1_hi", {16'h0, v}, 32'd0);
      chk("s1_busy", {31'h0, bus.Busy}, 32'h0);
      chk("s1_erro", {31'h0, bus.Erro}, 32'h0);
      chk("s1_opa",  {16'h0, bus.Mul_Multiplicando}, 32'd3);
      @(negedge clk);

      // 0xFFFF x 0xFFFF
      issue(16'hFFFF, 16'hFFFF);
      wait_ready(200, bc, sc);
      bus.Rd_Req = 1'b1;
      rd(1'b1, v); chk("s2_hi", {16'h0, v}, 32'hFFFE);
      rd(1'b0, v); chk("s2_lo", {16'h0, v}, 32'h0001);
      chk("s2_stall_idle", {31'h0, bus.Stall}, 32'h0);
      bus.Rd_Req = 1'b0;
      @(negedge clk);

      // 12 x 3 with a read pending throughout
      bus.Rd_Req = 1'b1;
      bus.Rd_Sel = 1'b0;
      issue(16'd12, 16'd3);
      chk("s3_stall_first", {31'h0, bus.Stall}, 32'h1);
      wait_ready(200, bc, sc);
      chk("s3_busy_cycles",  bc, 32'd7);
      chk("s3_stall_cycles", sc, 32'd7);
      chk("s3_stall_after",  {31'h0, bus.Stall}, 32'h0);
      rd(1'b0, v); chk("s3_lo", {16'h0, v}, 32'd36);
      bus.Rd_Req = 1'b0;
      @(negedge clk);

      // back-to-back with Req_Valid held, Done left high, Idle returning late
      idle_gap = 3;
      st0 = st_cnt;
      bus.Req_Valid = 1'b1;
      bus.Op_A = 16'd7;
      bus.Op_B = 16'd7;
      @(negedge clk);
      bus.Op_A = 16'd2;
      bus.Op_B = 16'd9;
      chk("s4_opa_held", {16'h0, bus.Mul_Multiplicando}, 32'd7);
      wait_ready(200, bc, sc);
      rd(1'b0, v); chk("s4_lo_first", {16'h0, v}, 32'd49);
      @(negedge clk);
      bus.Req_Valid = 1'b0;
      chk("s4_second_busy",  {31'h0, bus.Busy}, 32'h1);
      chk("s4_st_wait_idle", {31'h0, bus.Mul_St}, 32'h0);
      chk("s4_opa_second",   {16'h0, bus.Mul_Multiplicando}, 32'd2);
      wait_ready(200, bc, sc);
      rd(1'b0, v); chk("s4_lo_second", {16'h0, v}, 32'd18);
      repeat (6) @(negedge clk);
      chk("s4_st_pulses", st_cnt - st0, 32'd2);
      chk("s4_no_reaccept", {31'h0, bus.Busy}, 32'h0);
      idle_gap = 0;

      // timeout: Done never rises
      done_en = 1'b0;
      issue(16'd4, 16'd4);
      wait_ready(200, bc, sc);
      chk("s5_busy_cycles", bc, 32'd65);
      chk("s5_erro", {31'h0, bus.Erro}, 32'h1);
      rd(1'b0, v); chk("s5_lo_kept", {16'h0, v}, 32'd18);
      rd(1'b1, v); chk("s5_hi_kept", {16'h0, v}, 32'd0);
      @(negedge clk);
      done_en = 1'b1;
      issue(16'd3, 16'd5);
      chk("s5_erro_cleared", {31'h0, bus.Erro}, 32'h0);
      wait_ready(200, bc, sc);
      rd(1'b0, v); chk("s5_lo_after", {16'h0, v}, 32'd15);
      @(negedge clk);

      // reset during WAIT of 6 x 6
      lat = 20;
      issue(16'd6, 16'd6);
      repeat (4) @(negedge clk);
      chk("s6_busy_before", {31'h0, bus.Busy}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("s6_busy_rst", {31'h0, bus.Busy}, 32'h0);
      chk("s6_st_rst",   {31'h0, bus.Mul_St}, 32'h0);
      rd(1'b0, v); chk("s6_lo_rst", {16'h0, v}, 32'h0);
      rd(1'b1, v); chk("s6_hi_rst", {16'h0, v}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      rd(1'b0, v); chk("s6_lo_late_done", {16'h0, v}, 32'h0);
      rd(1'b1, v); chk("s6_hi_late_done", {16'h0, v}, 32'h0);
      chk("s6_idle_after", {31'h0, bus.Req_Ready}, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
